// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver.
// A prescaler divides clk into digit slots. Each slot first drives one
// blank "anti-ghost" cycle, then shows the decoded nibble of the current
// digit, which comes from a shadow register. seg, an and slot_tick are all
// registered.
// Optional feature: define SEVEN_SEG_LZ_BLANK_EN to blank leading zero
// digits. Digit 0 is always shown.
`timescale 1ns / 1ps

module seven_seg_scan_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  slot_tick
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CntW-1:0]   CntMax = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0]   IdxMax = IdxW'(DIGITS - 1);
  // Inactive output levels; XOR with these converts high-true to the pin polarity.
  localparam logic [6:0]        SegOff = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AnOff  = {DIGITS{ACTIVE_LOW}};

  // Standard hex glyphs, high-true, bit order {G,F,E,D,C,B,A}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                tick_q, tick_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                wrap;
  logic [DIGITS-1:0]   lz_blank;
  logic [DIGITS-1:0]   an_on;
  logic [3:0]          sel_nib;
  logic                sel_en;
  logic                sel_blank;
  logic                show;

  // Prescaler, digit index and shadow register next state.
  always_comb begin
    wrap     = (cnt_q == CntMax);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
    tick_d   = wrap;
    shadow_d = load ? value : shadow_q;
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic upper_zero;

  // Blank digit i when it and all more significant nibbles are zero.
  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      upper_zero  = upper_zero & (shadow_q[4*i +: 4] == 4'h0);
      lz_blank[i] = upper_zero;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Output next state is built from the next prescaler and index values,
  // so the registered outputs line up with the slot the counters are in.
  // Segment data comes from shadow_q, so a load becomes visible one edge
  // after the shadow register updates.
  always_comb begin
    an_on     = '0;
    sel_nib   = 4'h0;
    sel_en    = 1'b0;
    sel_blank = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_d == IdxW'(i)) begin
        an_on[i]  = 1'b1;
        sel_nib   = shadow_q[4*i +: 4];
        sel_en    = digit_en[i];
        sel_blank = lz_blank[i];
      end
    end

    // Prescaler 0 is the anti-ghost cycle. Masked or blanked digits stay dark for the whole slot.
    show  = (cnt_d != '0) && sel_en && !sel_blank;
    seg_d = SegOff;
    an_d  = AnOff;
    if (show) begin
      seg_d = hex_to_seg(sel_nib) ^ SegOff;
      an_d  = an_on ^ AnOff;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      tick_q   <= 1'b0;
      seg_q    <= SegOff;
      an_q     <= AnOff;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      tick_q   <= tick_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign slot_tick = tick_q;

endmodule
